std_fifo: RTL and testbench
===========================

STD_FIFO -- requirements
Module: std_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of wr_data and rd_data in bits.
REQ-002 Parameter DEPTH, default 32, SHALL set the storage capacity in words and SHALL be a power of two, 2 or greater.
REQ-003 Port clk, input, 1, SHALL be the single clock; one clock, all logic on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset, asynchronous and active-low.
REQ-005 Port wr_en, input, 1, SHALL be the write request.
REQ-006 Port wr_data, input, DATA_WIDTH, SHALL be the write word.
REQ-007 Port full, output, 1, SHALL be high when DEPTH words are stored.
REQ-008 Port rd_en, input, 1, SHALL be the read request.
REQ-009 Port rd_data, output, DATA_WIDTH, SHALL be the registered read word.
REQ-010 Port empty, output, 1, SHALL be high when zero words are stored.

Function
REQ-011 Write: wr_en=1 and full=0 at an edge SHALL store wr_data at the write pointer and advance it by 1.
REQ-012 wr_en=1 while full=1 SHALL be ignored, with no pointer, storage or flag change.
REQ-013 Read: rd_en=1 and empty=0 at an edge SHALL load rd_data with the oldest word (1-cycle latency) and advance the read pointer.
REQ-014 rd_en=1 while empty=1 SHALL be ignored, and rd_data SHALL hold its last value.
REQ-015 rd_data SHALL hold its value between accepted reads.
REQ-016 Pointers SHALL be log2(DEPTH)+1 bits wide, with the MSB acting as the wrap bit, and SHALL wrap modulo 2*DEPTH.
REQ-017 empty SHALL equal (wr_ptr == rd_ptr), and full SHALL equal (MSBs differ and lower bits equal).
REQ-018 Both flags SHALL be registered or derived from registered pointers, and SHALL update in the cycle after the causing edge.
REQ-019 Simultaneous accepted read and write SHALL leave the occupancy unchanged.
REQ-020 When full=1, a simultaneous write SHALL be rejected even if a read is accepted in the same cycle.
REQ-021 When empty=1, a simultaneous read SHALL be rejected even if a write is accepted in the same cycle.
REQ-022 Data order SHALL be strictly first-in first-out across any number of pointer wraps.

Reset
REQ-023 rst_n=0 SHALL immediately clear both pointers, set empty=1, full=0 and rd_data=0, and need not clear storage.
REQ-024 Reset asserted mid-operation SHALL discard all stored words, and operations SHALL resume on the first edge after rst_n goes high.

Configuration
REQ-025 With macro STD_FIFO_LEVEL_EN defined, the block SHALL add an output level of log2(DEPTH)+1 bits equal to (wr_ptr - rd_ptr), reset to 0 and updated like the flags.
REQ-026 With STD_FIFO_LEVEL_EN undefined, the level port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package std_fifo_pkg SHALL hold the default DATA_WIDTH and DEPTH constants and the pointer-width function (clog2(DEPTH)+1).
REQ-028 Storage SHALL be a sub-module std_fifo_ram (one write port, one registered read port), instantiated once.
REQ-029 Pointer and flag logic SHALL reside in std_fifo.

Verification
REQ-030 Reset then idle -> empty=1, full=0, rd_data=0.
REQ-031 Hold wr_en for 35 cycles with data 1..35 -> full=1 after the 32nd write; writes 33..35 are dropped; level=32 when enabled.
REQ-032 Read 35 cycles from full -> rd_data returns 1..32 in order, empty=1 after the 32nd read, and rd_data holds 32 for the remaining cycles.
REQ-033 Repeat fill with 36..70, then drain -> 36..67 are returned in order, proving pointer wrap.
REQ-034 At occupancy 5, simultaneous rd_en and wr_en for 10 cycles -> occupancy stays 5, FIFO order is preserved, and the flags do not toggle.
REQ-035 Assert rst_n=0 at occupancy 10 -> empty=1 at once, then a subsequent write of 0xAA followed by a read returns 0xAA.

Source files
------------

// File: rtl/std_fifo_pkg.sv
// Shared constants and helpers for the std_fifo block.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package std_fifo_pkg;

  // Default word width in bits.
  localparam int DEF_DATA_WIDTH = 8;

  // Default capacity in words; must be a power of two, 2 or greater.
  localparam int DEF_DEPTH = 32;

  // Pointer width: address bits plus one wrap bit, so that a full FIFO
  // (pointers DEPTH apart) is distinguishable from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when depth is a legal capacity (power of two, 2 or greater).
  function automatic bit depth_is_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage : std_fifo_pkg

// File: rtl/std_fifo_ram.sv
// Simple dual-port storage for std_fifo: one write port, one registered read port.
// Latency: write lands at the clock edge; read data appears one cycle after i_re.
// Backpressure: none; the caller only issues accepted writes and reads.
module std_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int WORDS = 1 << ADDR_W;

  // Storage is intentionally left unreset: stale contents are never read
  // because the pointers gate every read.
  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port: store the word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port: cleared by reset, otherwise holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : std_fifo_ram

// File: rtl/std_fifo.sv
// Synchronous single-clock FIFO with wrap-bit pointers; optional level output under STD_FIFO_LEVEL_EN.
// Latency: write visible in flags one cycle after the edge; rd_data registered, 1 cycle after accepted read.
// Backpressure: writes while full and reads while empty are silently dropped; no state changes.
module std_fifo
  import std_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
`ifdef STD_FIFO_LEVEL_EN
  ,
  output logic [ptr_width(DEPTH)-1:0] level
`endif
);

  // DEPTH must satisfy depth_is_legal(); the wrap-bit scheme relies on the
  // address field covering exactly DEPTH words.
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_wr_addr = r_wr_ptr[ADDR_W-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_W-1:0];

  // Flags come straight from the registered pointers, so they settle in the
  // cycle after whichever edge moved a pointer.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
              (w_wr_addr == w_rd_addr);
  end

  // Acceptance uses the current flags only: a read never frees room for a
  // same-cycle write, and a write never supplies data for a same-cycle read.
  always_comb begin
    w_wr_acc = wr_en && !w_full;
    w_rd_acc = rd_en && !w_empty;
  end

  // Write pointer advances by one per accepted write, wrapping mod 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances by one per accepted read, wrapping mod 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  std_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (w_wr_addr),
    .i_wdata (wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (w_rd_addr),
    .o_rdata (rd_data)
  );

  assign empty = w_empty;
  assign full  = w_full;

`ifdef STD_FIFO_LEVEL_EN
  // Occupancy is the modular pointer difference; the wrap bit makes DEPTH
  // itself representable.
  assign level = r_wr_ptr - r_rd_ptr;
`endif

endmodule : std_fifo

// File: tb/tb_std_fifo.sv
// Self-checking bench for std_fifo against a queue-based reference model.
// Latency: model expects registered rd_data and flags one cycle after each edge.
// Backpressure: model drops writes at DEPTH words and reads at zero words.
module tb_std_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
`ifdef STD_FIFO_LEVEL_EN
  logic [5:0]    level;
`endif

  std_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty)
`ifdef STD_FIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue plus the last word handed out.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rd;

  int unsigned n_vec;
  int unsigned n_err;

  // One clock of stimulus; model updated from its own pre-edge occupancy.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
    bit aw;
    bit ar;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    aw = we && (m_q.size() < DEPTH);
    ar = re && (m_q.size() != 0);
    if (ar) m_rd = m_q.pop_front();
    if (aw) m_q.push_back(wd);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    rst_n = 1'b0;
    m_q.delete();
    m_rd = '0;
    #2;
    n_vec++;
    if ({empty, full, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_async got e=%b f=%b d=%h want e=1 f=0 d=00", empty, full, rd_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      n_vec++;
      if ({empty, full, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
        n_err++;
        $display("FAIL reset_idle got e=%b f=%b d=%h want e=1 f=0 d=00", empty, full, rd_data);
      end
    end
  endtask

  task automatic test_fill(input int base);
    for (int i = 1; i <= 35; i++) begin
      cycle(1'b1, 8'(base + i - 1), 1'b0);
      n_vec++;
      if ({empty, full, rd_data} !== {m_q.size() == 0, m_q.size() == DEPTH, m_rd}) begin
        n_err++;
        $display("FAIL fill_%0d got e=%b f=%b d=%h want e=%b f=%b d=%h", i, empty, full, rd_data,
                 m_q.size() == 0, m_q.size() == DEPTH, m_rd);
      end
      if (i >= 32) begin
        n_vec++;
        if (full !== 1'b1) begin
          n_err++;
          $display("FAIL fill_full_%0d got %b want 1", i, full);
        end
      end
`ifdef STD_FIFO_LEVEL_EN
      n_vec++;
      if (level !== 6'((i > 32) ? 32 : i)) begin
        n_err++;
        $display("FAIL fill_level_%0d got %0d want %0d", i, level, (i > 32) ? 32 : i);
      end
`endif
    end
  endtask

  task automatic test_drain(input int base);
    for (int i = 1; i <= 35; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_vec++;
      if (rd_data !== 8'(base + ((i > 32) ? 32 : i) - 1)) begin
        n_err++;
        $display("FAIL drain_data_%0d got %h want %h", i, rd_data, 8'(base + ((i > 32) ? 32 : i) - 1));
      end
      n_vec++;
      if ({empty, full} !== {i >= 32, 1'b0}) begin
        n_err++;
        $display("FAIL drain_flags_%0d got e=%b f=%b want e=%b f=0", i, empty, full, i >= 32);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      n_vec++;
      if ({empty, full, rd_data} !== {1'b0, 1'b0, m_rd} || m_q.size() != 5) begin
        n_err++;
        $display("FAIL b2b_%0d got e=%b f=%b d=%h want e=0 f=0 d=%h occ=5", i, empty, full, rd_data, m_rd);
      end
`ifdef STD_FIFO_LEVEL_EN
      n_vec++;
      if (level !== 6'd5) begin
        n_err++;
        $display("FAIL b2b_level_%0d got %0d want 5", i, level);
      end
`endif
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_vec++;
      if (rd_data !== m_rd) begin
        n_err++;
        $display("FAIL b2b_drain_%0d got %h want %h", i, rd_data, m_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    m_q.delete();
    m_rd = '0;
    #1;
    n_vec++;
    if ({empty, full, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL midreset got e=%b f=%b d=%h want e=1 f=0 d=00", empty, full, rd_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'hAA, 1'b0);
    n_vec++;
    if ({empty, full} !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_write got e=%b f=%b want e=0 f=0", empty, full);
    end
    cycle(1'b0, 8'h00, 1'b1);
    n_vec++;
    if ({empty, rd_data} !== {1'b1, 8'hAA}) begin
      n_err++;
      $display("FAIL midreset_read got e=%b d=%h want e=1 d=aa", empty, rd_data);
    end
  endtask

  task automatic test_random();
    int wpct;
    int rpct;
    for (int i = 0; i < 800; i++) begin
      // Phases bias toward filling or draining so both flags get exercised.
      case ((i / 100) % 4)
        0:       begin wpct = 85; rpct = 20; end
        1:       begin wpct = 50; rpct = 50; end
        2:       begin wpct = 15; rpct = 85; end
        default: begin wpct = 60; rpct = 60; end
      endcase
      cycle($urandom_range(0, 99) < wpct, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < rpct);
      n_vec++;
      if ({empty, full, rd_data} !== {m_q.size() == 0, m_q.size() == DEPTH, m_rd}) begin
        n_err++;
        $display("FAIL random_%0d got e=%b f=%b d=%h want e=%b f=%b d=%h", i, empty, full, rd_data,
                 m_q.size() == 0, m_q.size() == DEPTH, m_rd);
      end
`ifdef STD_FIFO_LEVEL_EN
      n_vec++;
      if (level !== 6'(m_q.size())) begin
        n_err++;
        $display("FAIL random_level_%0d got %0d want %0d", i, level, m_q.size());
      end
`endif
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    test_reset();
    test_fill(1);
    test_drain(1);
    test_fill(36);
    test_drain(36);
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_std_fifo
